// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage execute unit: op codes, FSM states, op classification.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_EQ      = 4'b1000;
  localparam logic [3:0] ALU_SRA     = 4'b1001;
  localparam logic [3:0] ALU_NE      = 4'b1010;
  localparam logic [3:0] ALU_SLT_ALT = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational evaluation of the one-cycle ops; with ALU_FAST_SHIFT_EN it also barrel-shifts.
module alu_single_cycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
`ifdef ALU_FAST_SHIFT_EN
  input  logic [$clog2(DATA_WIDTH)-1:0] shamt,
`endif
  output logic [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = '0;
    case (op)
      ALU_AND:              y = a & b;
      ALU_OR:               y = a | b;
      ALU_ADD:              y = a + b;
      ALU_XOR:              y = a ^ b;
      ALU_SUB:              y = a - b;
      ALU_SLT, ALU_SLT_ALT: y = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_EQ:               y = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      ALU_NE:               y = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:              y = a << shamt;
      ALU_SRL:              y = a >> shamt;
      ALU_SRA:              y = a_s >>> shamt;
`else
      // Only zero-amount shifts reach this path; anything else iterates in the top.
      ALU_SLL, ALU_SRL, ALU_SRA: y = a;
`endif
      default:              y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative_exec.sv
// EX-stage execute unit with valid/ready handshake; shifts iterate one bit per cycle
// unless ALU_FAST_SHIFT_EN selects the single-cycle barrel shifter.
module alu_iterative_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult
);

  alu_state_t              state, state_nxt;
  logic [DATA_WIDTH-1:0]   acc, acc_nxt;
  logic [DATA_WIDTH-1:0]   sc_result;
  logic [SHAMT_WIDTH-1:0]  shamt;

  assign shamt = SrcB[SHAMT_WIDTH-1:0];

  alu_single_cycle #(.DATA_WIDTH(DATA_WIDTH)) u_single_cycle (
    .op    (Operation),
    .a     (SrcA),
    .b     (SrcB),
`ifdef ALU_FAST_SHIFT_EN
    .shamt (shamt),
`endif
    .y     (sc_result)
  );

`ifdef ALU_FAST_SHIFT_EN

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: if (in_valid) begin
        acc_nxt   = sc_result;
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
    end
  end

`else

  logic [SHAMT_WIDTH-1:0] cnt, cnt_nxt;
  logic [3:0]             op_q, op_nxt;

  function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [3:0] op,
                                                      input logic [DATA_WIDTH-1:0] v);
    case (op)
      ALU_SLL: return {v[DATA_WIDTH-2:0], 1'b0};
      ALU_SRA: return {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: return {1'b0, v[DATA_WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    case (state)
      IDLE: if (in_valid) begin
        op_nxt = Operation;
        if (is_shift(Operation) && (shamt != '0)) begin
          acc_nxt   = SrcA;
          cnt_nxt   = shamt;
          state_nxt = SHIFT;
        end else begin
          acc_nxt   = sc_result;
          state_nxt = DONE;
        end
      end
      SHIFT: begin
        acc_nxt = shift_one(op_q, acc);
        cnt_nxt = cnt - SHAMT_WIDTH'(1);
        // The cycle that consumes the last count performs the final shift.
        if (cnt == SHAMT_WIDTH'(1)) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_q  <= ALU_AND;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ALUResult = acc;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec: behavioural latency/result model plus literal expectations.
module tb_alu_iterative_exec;

  localparam int W = 32;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   Operation = 4'h0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] ALUResult;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_iterative_exec #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult)
  );

  function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int sh;
    logic signed [W-1:0] as, bs;
    sh = int'(b[4:0]);
    as = a;
    bs = b;
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a ^ b;
      4'h4: return a << sh;
      4'h5: return a >> sh;
      4'h6: return a - b;
      4'h7, 4'hF: return (as < bs) ? 1 : 0;
      4'h8: return (a == b) ? 1 : 0;
      4'h9: return as >>> sh;
      4'hA: return (a != b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (!FAST && (op == 4'h4 || op == 4'h5 || op == 4'h9) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Transaction-level model: busy flag, cycles left until the result shows, result value.
  bit           m_busy  = 1'b0;
  bit           m_valid = 1'b0;
  int           m_wait  = 0;
  logic [W-1:0] m_res   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_wait  = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1'b1;
    end else if (in_valid) begin
      m_busy  = 1'b1;
      m_res   = model_res(Operation, SrcA, SrcB);
      m_wait  = model_lat(Operation, SrcB) - 1;
      m_valid = (m_wait == 0);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("model_in_ready", W'(in_ready), W'(!m_busy));
      check("model_out_valid", W'(out_valid), W'(m_valid));
      if (m_valid) check("model_result", ALUResult, m_res);
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat, input int hold);
    int n;
    @(negedge clk);
    check("accept_ready", W'(in_ready), W'(1));
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid  = 1'b0;
    Operation = 4'hB;
    SrcA      = ~a;
    SrcB      = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency", W'(n), W'(exp_lat));
    check("result", ALUResult, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      Operation = 4'h2;
      SrcA      = 32'h1;
      SrcB      = 32'h1;
      @(negedge clk);
      check("hold_result", ALUResult, exp);
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_out_valid", W'(out_valid), W'(1));
    end
    if (hold != 0) begin
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", W'(in_ready), W'(1));
      check("release_out_valid", W'(out_valid), W'(0));
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_result", ALUResult, W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));

    run_op(4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0);
    run_op(4'h6, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0);
    run_op(4'h9, 32'h80000000, 32'h00000004, 32'hF8000000, FAST ? 1 : 5, 0);
    run_op(4'h5, 32'h80000000, 32'h00000004, 32'h08000000, FAST ? 1 : 5, 0);
    run_op(4'h9, 32'h40000000, 32'h00000003, 32'h08000000, FAST ? 1 : 4, 0);
    run_op(4'h4, 32'h12345678, 32'h00000020, 32'h12345678, 1, 0);
    run_op(4'h4, 32'h00000001, 32'h0000001F, 32'h80000000, FAST ? 1 : 32, 0);
    run_op(4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0);
    run_op(4'hF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0);
    run_op(4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0);
    run_op(4'h8, 32'h00000005, 32'h00000005, 32'h00000001, 1, 0);
    run_op(4'hA, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0);
    run_op(4'hC, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0);
    run_op(4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0);
    run_op(4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, 0);
    run_op(4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 10);

    // Reset while a 20-bit shift is in progress.
    @(negedge clk);
    out_ready = 1'b0;
    Operation = 4'h4;
    SrcA      = 32'h00000001;
    SrcB      = 32'd20;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_result", ALUResult, W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    run_op(4'h2, 32'h00000003, 32'h00000004, 32'h00000007, 1, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_iterative_exec.md
# alu_iterative_exec

Multi-cycle execute unit consuming the 4-bit `Operation` code produced by the ALU controller together with the two source operands; returns the result over a valid/ready handshake. Logic, arithmetic, compare and branch-compare operations complete in one cycle. Shifts iterate one bit per cycle, unless the barrel-shift option is compiled in. Sits in the EX stage between operand muxing and the EX/MEM register; the pipeline stalls while `in_ready` is low.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `SHAMT_WIDTH`, $clog2(DATA_WIDTH), shift-amount bits taken from `SrcB[SHAMT_WIDTH-1:0]`
- `clk  input  1  clock; all state on rising edge`
- `rst_n  input  1  asynchronous, active-low reset`
- `in_valid  input  1  request present`
- `in_ready  output  1  unit can accept; high only in IDLE`
- `Operation  input  4  operation code (encoding under Operation)`
- `SrcA  input  DATA_WIDTH  operand A / shift source`
- `SrcB  input  DATA_WIDTH  operand B / shift amount`
- `out_valid  output  1  ALUResult valid; high only in DONE`
- `out_ready  input  1  consumer takes result`
- `ALUResult  output  DATA_WIDTH  result, stable while out_valid`

## Operation
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed)
  - 1000 EQ (result 1 if SrcA==SrcB, else 0)
  - 1001 SRA
  - 1010 NE (1 if SrcA!=SrcB)
  - 1111 SLT (alias of 0111)
  - 1011/1100/1101/1110 → result 0
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- SLT/EQ/NE results are zero-extended to DATA_WIDTH.
- Operands and Operation are captured on the accept edge; later input changes are ignored.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid:
    - Shift op with shamt≠0 → load acc=SrcA and cnt=shamt, go to SHIFT.
    - Otherwise → compute result into acc, go to DONE.
  - SHIFT: each cycle acc shifts by 1 bit (SLL fills 0; SRL fills 0; SRA fills acc MSB) and cnt decrements. When cnt reaches 1, perform that final shift and go to DONE.
  - DONE: out_valid=1, ALUResult=acc. On out_ready → IDLE. Otherwise hold state and result.
- Shamt 0 behaves as a non-shift op: result = SrcA.
- Only one operation is in flight at a time. No new accept in DONE, even if out_ready=1 in that cycle.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, acc=0, cnt=0, in_ready=1, out_valid=0, ALUResult=0.
- Reset mid-SHIFT or mid-DONE aborts the operation immediately; the pending result is discarded.
- Latency from accept edge to out_valid high:
  - Non-shift: 1 cycle.
  - Shift with shamt k≥1: k+1 cycles (k in SHIFT, then DONE).
- Min issue interval: 2 cycles (IDLE→DONE→IDLE) with out_ready tied high.
- in_ready and out_valid are registered-state decodes with no combinational path from inputs. They are never high together.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter; SHIFT state and cnt are removed.
  - All ops have 1-cycle latency. Results are identical to the iterative path.
- Undefined: iterative shifter as described under Operation.

## Structure
- Shared package `alu_pkg` holds:
  - Localparams for all 12 op codes (ALU_AND … ALU_SLT_ALT)
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t`
- One sub-module, `alu_single_cycle`: purely combinational evaluation of the non-iterative ops (and the barrel shift under `ALU_FAST_SHIFT_EN`). The top holds the FSM, acc and cnt.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, out_valid one cycle after accept. SUB 0 - 1 → 0xFFFFFFFF.
- SRA SrcA=0x80000000, SrcB=4 → 0xF8000000 after 5 cycles. SRL same operands → 0x08000000. With `ALU_FAST_SHIFT_EN`, both results arrive after 1 cycle.
- SLL shamt 0 (SrcB=0x20) → SrcA unchanged, 1-cycle latency. SLL 1 by 31 → 0x80000000 after 32 cycles.
- SLT -1 vs 1 → 1. Op 1111 with same operands → 1. EQ 5,5 → 1; NE 5,5 → 0. Op 1100 → 0.
- Backpressure: out_ready low for 10 cycles in DONE → ALUResult stable, in_ready=0, new in_valid ignored. Then out_ready=1 → IDLE next cycle.
- rst_n asserted at cycle 3 of a 20-bit shift → all outputs 0 immediately, in_ready=1 after release. A following ADD completes correctly.
